// File: rtl/alerm_set_ctrl.sv
// Alarm-time setting controller: key-driven hour/minute/second BCD editing via a shadow register.
// Optional macro ALERM_EDIT_TIMEOUT_EN adds an idle timeout that auto-commits an open edit.
module alerm_set_ctrl #(
  parameter int unsigned second_cnt  = 50_000_000,
  parameter int unsigned timeout_sec = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        key_mode,
  input  logic        key_inc,
  input  logic        key_enable,
  output logic [23:0] alerm_data,
  output logic        alerm_enable,
  output logic [1:0]  edit_field,
  output logic [23:0] edit_data,
  output logic        edit_blink
);

  localparam int unsigned PreW = (second_cnt > 2) ? $clog2(second_cnt) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(second_cnt - 1);
  localparam logic [PreW-1:0] PreHalf = PreW'(second_cnt / 2);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StEditH = 2'd1,
    StEditM = 2'd2,
    StEditS = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [23:0]     alerm_q, alerm_d;
  logic [23:0]     shadow_q, shadow_d;
  logic            enable_q, enable_d;
  logic            alerm_en_q, alerm_en_d;
  logic            blink_q, blink_d;
  logic [PreW-1:0] presc_q, presc_d;
  logic            tick;

  // Two-digit BCD increment wrapping to 00 after max (max is itself BCD).
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r;
    if (v == max) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  assign tick = (presc_q == PreLast);

`ifdef ALERM_EDIT_TIMEOUT_EN
  localparam int unsigned SecW = (timeout_sec > 1) ? $clog2(timeout_sec + 1) : 1;
  localparam logic [SecW-1:0] SecLast = SecW'(timeout_sec - 1);

  logic [SecW-1:0] sec_q, sec_d;
  logic            timeout;

  always_comb begin
    sec_d   = sec_q;
    timeout = 1'b0;
    if (state_q == StIdle || key_mode || key_inc) begin
      sec_d = '0;
    end else if (tick) begin
      if (sec_q == SecLast) begin
        sec_d   = '0;
        timeout = 1'b1;
      end else begin
        sec_d = sec_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sec_q <= '0;
    end else begin
      sec_q <= sec_d;
    end
  end
`else
  logic timeout;
  logic unused_timeout_cfg;

  assign timeout            = 1'b0;
  assign unused_timeout_cfg = (timeout_sec == 0);
`endif

  always_comb begin
    state_d  = state_q;
    alerm_d  = alerm_q;
    shadow_d = shadow_q;
    enable_d = enable_q ^ key_enable;
    presc_d  = tick ? '0 : presc_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        shadow_d = alerm_q;
        if (key_mode) begin
          state_d = StEditH;
        end
      end
      StEditH: begin
        if (key_mode) begin
          state_d = StEditM;
        end else if (key_inc) begin
          shadow_d[23:16] = bcd_inc(shadow_q[23:16], 8'h23);
        end
      end
      StEditM: begin
        if (key_mode) begin
          state_d = StEditS;
        end else if (key_inc) begin
          shadow_d[15:8] = bcd_inc(shadow_q[15:8], 8'h59);
        end
      end
      StEditS: begin
        if (key_mode) begin
          state_d = StIdle;
          alerm_d = shadow_q;
        end else if (key_inc) begin
          shadow_d[7:0] = bcd_inc(shadow_q[7:0], 8'h59);
        end
      end
      default: state_d = StIdle;
    endcase

    // Timeout only fires without a key pulse, so it never collides with an edit.
    if (timeout) begin
      state_d = StIdle;
      alerm_d = shadow_q;
    end

    // Outputs are registered from next-state so they all change together.
    alerm_en_d = enable_d && (state_d == StIdle);
    blink_d    = (state_d != StIdle) && (presc_d < PreHalf);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      alerm_q    <= '0;
      shadow_q   <= '0;
      enable_q   <= 1'b0;
      alerm_en_q <= 1'b0;
      blink_q    <= 1'b0;
      presc_q    <= '0;
    end else begin
      state_q    <= state_d;
      alerm_q    <= alerm_d;
      shadow_q   <= shadow_d;
      enable_q   <= enable_d;
      alerm_en_q <= alerm_en_d;
      blink_q    <= blink_d;
      presc_q    <= presc_d;
    end
  end

  assign alerm_data   = alerm_q;
  assign alerm_enable = alerm_en_q;
  assign edit_field   = state_q;
  assign edit_data    = shadow_q;
  assign edit_blink   = blink_q;

endmodule

// File: tb/tb_alerm_set_ctrl.sv
// Self-checking bench for alerm_set_ctrl: integer-time reference model plus directed key sequences.
module tb_alerm_set_ctrl;

  localparam int N = 4;
  localparam int T = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        key_mode = 1'b0;
  logic        key_inc = 1'b0;
  logic        key_enable = 1'b0;
  logic [23:0] alerm_data;
  logic        alerm_enable;
  logic [1:0]  edit_field;
  logic [23:0] edit_data;
  logic        edit_blink;

  int total = 0;
  int bad = 0;

  alerm_set_ctrl #(
    .second_cnt (N),
    .timeout_sec(T)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .key_mode    (key_mode),
    .key_inc     (key_inc),
    .key_enable  (key_enable),
    .alerm_data  (alerm_data),
    .alerm_enable(alerm_enable),
    .edit_field  (edit_field),
    .edit_data   (edit_data),
    .edit_blink  (edit_blink)
  );

  always #5 clock = ~clock;

  // Reference model: times as plain integers, field as 0..3, prescaler as cycle count mod N.
  int m_field, m_h, m_m, m_s, c_h, c_m, c_s, m_presc, m_secs, old_field;
  bit m_en;

  function automatic logic [23:0] to_bcd(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic commit_model();
    c_h = m_h;
    c_m = m_m;
    c_s = m_s;
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_field = 0; m_h = 0; m_m = 0; m_s = 0; c_h = 0; c_m = 0; c_s = 0;
      m_presc = 0; m_secs = 0; m_en = 1'b0;
    end else begin
      old_field = m_field;
      if (key_enable) m_en = !m_en;
      case (m_field)
        0: if (key_mode) m_field = 1;
        1: if (key_mode) m_field = 2; else if (key_inc) m_h = (m_h + 1) % 24;
        2: if (key_mode) m_field = 3; else if (key_inc) m_m = (m_m + 1) % 60;
        default: begin
          if (key_mode) begin
            m_field = 0;
            commit_model();
          end else if (key_inc) begin
            m_s = (m_s + 1) % 60;
          end
        end
      endcase
`ifdef ALERM_EDIT_TIMEOUT_EN
      if (old_field == 0 || key_mode || key_inc) begin
        m_secs = 0;
      end else if (m_presc == N - 1) begin
        m_secs++;
        if (m_secs == T) begin
          m_secs = 0;
          m_field = 0;
          commit_model();
        end
      end
`endif
      if (m_field == 0) begin
        m_h = c_h;
        m_m = c_m;
        m_s = c_s;
      end
      m_presc = (m_presc + 1) % N;
    end
  end

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    #1;
    chk("alerm_data", alerm_data, to_bcd(c_h, c_m, c_s));
    chk("edit_data", edit_data, to_bcd(m_h, m_m, m_s));
    chk("edit_field", 24'(edit_field), 24'(m_field));
    chk("alerm_enable", 24'(alerm_enable), 24'(m_en && m_field == 0));
    chk("edit_blink", 24'(edit_blink), 24'(m_field != 0 && m_presc < N / 2));
  end

  task automatic press(input bit m, input bit i, input bit e);
    @(negedge clock);
    key_mode = m;
    key_inc = i;
    key_enable = e;
    @(negedge clock);
    key_mode = 1'b0;
    key_inc = 1'b0;
    key_enable = 1'b0;
  endtask

  task automatic incs(input int n);
    for (int k = 0; k < n; k++) press(1'b0, 1'b1, 1'b0);
  endtask

  int ones;

  initial begin
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("lit reset alerm_data", alerm_data, 24'h000000);
    chk("lit reset field", 24'(edit_field), 24'd0);

    // Build shadow 0x120000 with the switch on, then reset mid-edit.
    press(1'b1, 1'b0, 1'b0);
    incs(12);
    press(1'b0, 1'b0, 1'b1);
    chk("lit shadow 12h", edit_data, 24'h120000);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("lit rst alerm_data", alerm_data, 24'h000000);
    chk("lit rst field", 24'(edit_field), 24'd0);
    chk("lit rst enable", 24'(alerm_enable), 24'd0);
    chk("lit rst blink", 24'(edit_blink), 24'd0);
    chk("lit rst edit_data", edit_data, 24'h000000);

    // Hour to 23 and commit, then hour wrap.
    press(1'b1, 1'b0, 1'b0);
    incs(23);
    chk("lit hour 23", edit_data, 24'h230000);
    repeat (3) press(1'b1, 1'b0, 1'b0);
    chk("lit commit 23h", alerm_data, 24'h230000);
    chk("lit idle field", 24'(edit_field), 24'd0);
    press(1'b1, 1'b0, 1'b0);
    incs(1);
    chk("lit hour wrap", edit_data, 24'h000000);
    chk("lit field hour", 24'(edit_field), 24'd1);

    // Minute carry 09->10, then second full wrap.
    press(1'b1, 1'b0, 1'b0);
    incs(9);
    chk("lit min 09", edit_data, 24'h000900);
    incs(1);
    chk("lit min 10", edit_data, 24'h001000);
    press(1'b1, 1'b0, 1'b0);
    incs(60);
    chk("lit sec wrap", edit_data, 24'h001000);
    press(1'b1, 1'b0, 1'b0);
    chk("lit commit 0010", alerm_data, 24'h001000);

    // Enable switch gating.
    press(1'b0, 1'b0, 1'b1);
    chk("lit enable on", 24'(alerm_enable), 24'd1);
    press(1'b1, 1'b0, 1'b0);
    chk("lit enable gated", 24'(alerm_enable), 24'd0);
    chk("lit field edit", 24'(edit_field), 24'd1);
    ones = 0;
    for (int k = 0; k < N; k++) begin
      @(negedge clock);
      ones += int'(edit_blink);
    end
    chk("lit blink duty", 24'(ones), 24'(N / 2));
    repeat (3) press(1'b1, 1'b0, 1'b0);
    chk("lit enable restored", 24'(alerm_enable), 24'd1);

    // Simultaneous keys.
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b1, 1'b0);
    chk("lit mode wins field", 24'(edit_field), 24'd2);
    chk("lit mode wins hour", edit_data, 24'h001000);
    press(1'b1, 1'b0, 1'b1);
    chk("lit mode+enable field", 24'(edit_field), 24'd3);
    press(1'b1, 1'b0, 1'b0);
    chk("lit mode+enable toggled", 24'(alerm_enable), 24'd0);

    // Idle in minute edit.
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    incs(1);
    chk("lit min 11", edit_data, 24'h001100);
    repeat (12) @(negedge clock);
`ifdef ALERM_EDIT_TIMEOUT_EN
    chk("lit timeout field", 24'(edit_field), 24'd0);
    chk("lit timeout commit", alerm_data, 24'h001100);
`else
    repeat (88) @(negedge clock);
    chk("lit no timeout field", 24'(edit_field), 24'd2);
    chk("lit no timeout data", alerm_data, 24'h001000);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    chk("lit late commit", alerm_data, 24'h001100);
`endif

    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
